eviction_write_buffer: RTL
==========================

// Module: eviction_write_buffer
// PURPOSE
//  Downstream neighbour of the third-level cache: absorbs the 89-bit D_PUSH eviction words the cache emits on
//  Desalojo, queues dirty lines, and drains them one at a time to main memory over a req/ack handshake.
//  Provides a same-cycle address lookup so the cache can forward data still waiting in the buffer.
//  Coalesces a new eviction onto a queued entry with the same address.
// PARAMETERS
//  DEPTH    8    number of entries; power of two, >= 2
//  ADDR_W   24   line address width (D_PUSH[87:64])
//  DATA_W   64   line data width (D_PUSH[63:0])
// PORTS
//  CLK          in   1        single clock, rising edge
//  Reset        in   1        synchronous, active-high
//  Push         in   1        D_PUSH valid this cycle (driven from cache Desalojo)
//  D_PUSH       in   89       [88]=dirty, [87:64]=address, [63:0]=data
//  Full         out  1        count == DEPTH
//  Empty        out  1        count == 0
//  Count        out  $clog2(DEPTH)+1   valid entries
//  Overflow     out  1        sticky: non-coalescing push rejected while Full
//  Mem_Req      out  1        write request to main memory
//  Mem_Addr     out  ADDR_W   head address, stable while Mem_Req
//  Mem_Data     out  DATA_W   head data, stable while Mem_Req
//  Mem_Ack      in   1        memory accepted the write (sampled only while Mem_Req)
//  Lookup_Addr  in   ADDR_W   cache probe address
//  Lookup_Hit   out  1        combinational: valid entry matches Lookup_Addr
//  Lookup_Data  out  DATA_W   data of youngest matching entry; 0 when no hit
// BEHAVIOUR
//  Reset: all entries invalid, pointers 0, Count=0, Empty=1, Full=0, Overflow=0, Mem_Req=0, FSM=IDLE;
//   Mem_Addr/Mem_Data=0. Reset during REQ drops Mem_Req next edge; late Mem_Ack ignored in IDLE.
//  Push with D_PUSH[88]=0 (clean): discarded, no state change.
//  Push dirty, address matches valid entry that is NOT the head in REQ: data overwritten in place,
//   Count unchanged, accepted even when Full.
//  Push dirty, no eligible match: appended at tail if Count<DEPTH; else dropped and Overflow<=1.
//   Full is evaluated on pre-edge Count; a pop in the same cycle does not free space for that push.
//  Drain FSM: IDLE -> REQ when !Empty (one-cycle bubble). REQ: Mem_Req=1, head fields presented;
//   on edge with Mem_Ack=1: head invalidated, head ptr++ (wraps mod DEPTH), Count--, -> IDLE.
//   Mem_Ack in IDLE ignored. No timeout; REQ holds indefinitely.
//  Simultaneous append + pop: Count unchanged, both pointers advance.
//  Coalesce onto head while in REQ is forbidden (would change Mem_Data mid-handshake) -> append instead.
//  Lookup: pure combinational, includes head in REQ; multiple matches -> youngest (closest to tail) wins.
//   Lookup does not see the word being pushed in the same cycle.
//  Address uniqueness is not guaranteed only for head-in-REQ + one appended copy; youngest-wins covers it.
//  Latency: dirty push at edge N -> Mem_Req earliest high after edge N+1 (if buffer was empty, FSM IDLE).
// STRUCTURE
//  Shared package cache_pkg: ADDR_W, DATA_W, ENTRY_W=1+ADDR_W+DATA_W, field bit-position constants
//   (DIRTY_BIT=88, ADDR_MSB/LSB, DATA_MSB/LSB), typedef struct packed evict_entry_t {dirty,addr,data},
//   typedef enum logic {WB_IDLE, WB_REQ} wb_state_t.
//  One sub-module: eviction_cam_match - DEPTH-way address compare over valid bits, age-ordered priority
//   from head/tail pointers, returns hit, one-hot match, youngest index; reused for lookup and coalesce.
// TESTING
//  1. Reset, push dirty {A=0x000010,D=0x11} -> Count=1; next cycle IDLE->REQ; Mem_Req=1, Mem_Addr=0x000010,
//     Mem_Data=0x11; Mem_Ack pulse -> Count=0, Empty=1, Mem_Req=0.
//  2. Push clean {A=0x000020} -> Count stays 0, Mem_Req never asserts.
//  3. Hold Mem_Ack=0, push 8 distinct dirty lines -> Full=1; 9th distinct push -> dropped, Overflow=1;
//     push matching addr of entry #3 with D=0xAA -> accepted, Count=8, Lookup_Addr=#3 -> Hit, Data=0xAA.
//  4. Head 0x000040 in REQ, push 0x000040 D=0x55 -> appended (Count+1), Mem_Data still old value;
//     Lookup 0x000040 -> Data=0x55; after ack, second write of 0x55 issued.
//  5. Full, Mem_Ack and new dirty push same edge -> push dropped, Overflow=1, Count=7.
//  6. Reset asserted while Mem_Req=1 -> Mem_Req=0, Count=0 next edge; Mem_Ack pulse afterwards -> no change.

Source files
------------

// File: rtl/eviction_write_buffer_pkg.sv
// Shared types for the L3 eviction write buffer.
// Field layout of D_PUSH, entry struct and drain FSM states.
package cache_pkg;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 64;
  localparam int ENTRY_W   = 1 + ADDR_W + DATA_W;
  localparam int DIRTY_BIT = ENTRY_W - 1;
  localparam int ADDR_MSB  = DIRTY_BIT - 1;
  localparam int ADDR_LSB  = DATA_W;
  localparam int DATA_MSB  = DATA_W - 1;
  localparam int DATA_LSB  = 0;

  typedef struct packed {
    logic              dirty;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } evict_entry_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/eviction_write_buffer_cam_match.sv
// Age-ordered address CAM over the buffer entries.
// Ports: i_valid/i_tbl/i_key/i_head in; o_hit, o_onehot, o_idx (youngest match) out.
module eviction_cam_match
  import cache_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = cache_pkg::ADDR_W
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_tbl,
  input  logic [ADDR_W-1:0]            i_key,
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  output logic                         o_hit,
  output logic [DEPTH-1:0]             o_onehot,
  output logic [$clog2(DEPTH)-1:0]     o_idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_i;
  logic [DEPTH-1:0] w_one;

  assign w_one = {{(DEPTH-1){1'b0}}, 1'b1};

  // Walk from oldest (head) to youngest; last match wins.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_i   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_i = i_head + PTR_W'(k);
      if (i_valid[w_i] && (i_tbl[w_i] == i_key)) begin
        o_hit = 1'b1;
        o_idx = w_i;
      end
    end
  end

  assign o_onehot = o_hit ? (w_one << o_idx) : '0;

endmodule

// File: rtl/eviction_write_buffer.sv
// Eviction write buffer: queues dirty L3 lines, coalesces, drains to memory.
// Ports: CLK/Reset, Push/D_PUSH in; status, Mem_* handshake, Lookup_* probe.
module eviction_write_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Push,
  input  logic [ADDR_W+DATA_W:0]   D_PUSH,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic                     Mem_Req,
  output logic [ADDR_W-1:0]        Mem_Addr,
  output logic [DATA_W-1:0]        Mem_Data,
  input  logic                     Mem_Ack,
  input  logic [ADDR_W-1:0]        Lookup_Addr,
  output logic                     Lookup_Hit,
  output logic [DATA_W-1:0]        Lookup_Data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_state_t                  r_state;
  logic [DEPTH-1:0]           r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]           r_head;
  logic [PTR_W-1:0]           r_tail;
  logic [CNT_W-1:0]           r_count;
  logic                       r_overflow;

  logic                       w_dirty;
  logic [ADDR_W-1:0]          w_paddr;
  logic [DATA_W-1:0]          w_pdata;
  logic [DEPTH-1:0]           w_head_oh;
  logic [DEPTH-1:0]           w_coal_valid;
  logic                       w_lk_hit;
  logic [DEPTH-1:0]           w_lk_oh;
  logic [PTR_W-1:0]           w_lk_idx;
  logic                       w_cm_hit;
  logic [DEPTH-1:0]           w_cm_oh;
  logic [PTR_W-1:0]           w_cm_idx;
  logic                       w_push;
  logic                       w_full;
  logic                       w_coal;
  logic                       w_app;
  logic                       w_drop;
  logic                       w_pop;

  assign w_dirty = D_PUSH[ADDR_W+DATA_W];
  assign w_paddr = D_PUSH[ADDR_W+DATA_W-1 -: ADDR_W];
  assign w_pdata = D_PUSH[DATA_W-1:0];

  // Head is being written to memory while in REQ; keep it out of coalescing.
  assign w_head_oh = {{(DEPTH-1){1'b0}}, 1'b1} << r_head;
  assign w_coal_valid = (r_state == WB_REQ) ? (r_valid & ~w_head_oh) : r_valid;

  eviction_cam_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_lookup (
    .i_valid  (r_valid),
    .i_tbl    (r_addr),
    .i_key    (Lookup_Addr),
    .i_head   (r_head),
    .o_hit    (w_lk_hit),
    .o_onehot (w_lk_oh),
    .o_idx    (w_lk_idx)
  );

  eviction_cam_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_coal (
    .i_valid  (w_coal_valid),
    .i_tbl    (r_addr),
    .i_key    (w_paddr),
    .i_head   (r_head),
    .o_hit    (w_cm_hit),
    .o_onehot (w_cm_oh),
    .o_idx    (w_cm_idx)
  );

  assign w_push = Push & w_dirty;
  assign w_full = (r_count == CNT_FULL);
  assign w_coal = w_push & (|w_cm_oh);
  assign w_app  = w_push & ~w_cm_hit & ~w_full;
  assign w_drop = w_push & ~w_cm_hit & w_full;
  assign w_pop  = (r_state == WB_REQ) & Mem_Ack;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= WB_IDLE;
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_app) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_app && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_app) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      unique case (r_state)
        WB_IDLE: if (r_count != '0) r_state <= WB_REQ;
        WB_REQ:  if (Mem_Ack) r_state <= WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_app) begin
      r_addr[r_tail] <= w_paddr;
      r_data[r_tail] <= w_pdata;
    end
    if (w_coal) begin
      r_data[w_cm_idx] <= w_pdata;
    end
  end

  assign Full        = w_full;
  assign Empty       = (r_count == '0);
  assign Count       = r_count;
  assign Overflow    = r_overflow;
  assign Mem_Req     = (r_state == WB_REQ);
  assign Mem_Addr    = Mem_Req ? r_addr[r_head] : '0;
  assign Mem_Data    = Mem_Req ? r_data[r_head] : '0;
  assign Lookup_Hit  = |w_lk_oh;
  assign Lookup_Data = w_lk_hit ? r_data[w_lk_idx] : '0;

endmodule
